// File: rtl/clint_if.sv
// Native data-bus port bundle between the core and the CLINT.
// The master issues requests: mem_valid, mem_addr, mem_wdata, and mem_wstrb
// (mem_wstrb == 0 means a read). The slave answers one cycle later with
// mem_ready and mem_rdata.
interface clint_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/clint.sv
// Single-hart core-local interruptor.
// The block holds the 64-bit mtime counter, mtimecmp, and msip. mtime
// advances on an RTC tick that is divided down from the core clock.
//
// Ports:
//   clock, reset  core clock and asynchronous active-low reset
//   bus           native data-bus slave. It responds with fixed
//                 1-cycle latency and has no backpressure.
//   clint_msip    machine software interrupt pending (msip bit 0)
//   clint_mtip    machine timer interrupt pending, registered (mtime >= mtimecmp)
//   clint_mtime   current mtime, for the time/timeh CSRs
module clint #(
  parameter int unsigned clk_divider_rtc = 9
) (
  input  logic        clock,
  input  logic        reset,
  clint_if.slave      bus,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);
  localparam int RW = (clk_divider_rtc > 0) ? $clog2(clk_divider_rtc + 1) : 1;
  localparam logic [RW-1:0] RTC_MAX = RW'(clk_divider_rtc);

  // Word offsets, mem_addr[15:2]
  localparam logic [13:0] A_MSIP    = 14'h0000;
  localparam logic [13:0] A_CMP_LO  = 14'h1000;
  localparam logic [13:0] A_CMP_HI  = 14'h1001;
  localparam logic [13:0] A_TIME_LO = 14'h2FFE;
  localparam logic [13:0] A_TIME_HI = 14'h2FFF;

  logic [RW-1:0] rtc_count_q, rtc_count_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          mtip_q, mtip_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          tick, wr, rd;
  logic [13:0]   word;

  // The window decode is done upstream, so only the word index matters here.
  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr[31:16], bus.mem_addr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  always_comb begin
    word = bus.mem_addr[15:2];
    wr   = bus.mem_valid && (bus.mem_wstrb != 4'b0000);
    rd   = bus.mem_valid && (bus.mem_wstrb == 4'b0000);
    tick = (rtc_count_q == RTC_MAX);

    rtc_count_d = tick ? '0 : rtc_count_q + RW'(1);
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    rdata_d     = 32'h0;

    // A bus write to either mtime word overrides the tick for that cycle.
    // The divider still advances, so that tick is lost.
    if (wr) begin
      case (word)
        A_MSIP:    if (bus.mem_wstrb[0]) msip_d = bus.mem_wdata[0];
        A_CMP_LO:  mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0],  bus.mem_wdata, bus.mem_wstrb);
        A_CMP_HI:  mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], bus.mem_wdata, bus.mem_wstrb);
        A_TIME_LO: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], bus.mem_wdata, bus.mem_wstrb)};
        A_TIME_HI: mtime_d = {merge(mtime_q[63:32], bus.mem_wdata, bus.mem_wstrb), mtime_q[31:0]};
        default: ;
      endcase
    end

    // Reads return the pre-update register contents. Write responses read 0.
    if (rd) begin
      case (word)
        A_MSIP:    rdata_d = {31'h0, msip_q};
        A_CMP_LO:  rdata_d = mtimecmp_q[31:0];
        A_CMP_HI:  rdata_d = mtimecmp_q[63:32];
        A_TIME_LO: rdata_d = mtime_q[31:0];
        A_TIME_HI: rdata_d = mtime_q[63:32];
        default:   rdata_d = 32'h0;
      endcase
    end

    mtip_d  = (mtime_q >= mtimecmp_q);
    ready_d = bus.mem_valid;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rtc_count_q <= '0;
      mtime_q     <= 64'h0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      mtip_q      <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      rtc_count_q <= rtc_count_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      mtip_q      <= mtip_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign clint_msip    = msip_q;
  assign clint_mtip    = mtip_q;
  assign clint_mtime   = mtime_q;
endmodule

// File: tb/tb_clint.sv
module tb_clint;
  localparam int DIV = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clint_msip, clint_mtip;
  logic [63:0] clint_mtime;

  clint_if bus();

  clint #(.clk_divider_rtc(DIV)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .clint_msip(clint_msip), .clint_mtip(clint_mtip), .clint_mtime(clint_mtime)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  // The model keeps the architectural registers and counts the clock edges
  // since reset release. A tick falls on every (DIV+1)-th edge.
  logic [63:0] m_time, m_cmp;
  logic        m_msip;
  longint      m_edges;
  logic        e_ready, e_mtip;
  logic [31:0] e_rdata;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [15:0] off;
    off = {a[15:2], 2'b00};
    if (off == 16'h0000) return {31'h0, m_msip};
    if (off == 16'h4000) return m_cmp[31:0];
    if (off == 16'h4004) return m_cmp[63:32];
    if (off == 16'hBFF8) return m_time[31:0];
    if (off == 16'hBFFC) return m_time[63:32];
    return 32'h0;
  endfunction

  function automatic logic [63:0] put_bytes(input logic [63:0] v, input int hi,
                                            input logic [31:0] d, input logic [3:0] s);
    logic [63:0] r;
    r = v;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[hi*32 + b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] next_time(input logic [63:0] t, input longint edges,
                                            input logic v, input logic [31:0] a,
                                            input logic [31:0] d, input logic [3:0] s);
    logic [15:0] off;
    off = {a[15:2], 2'b00};
    if (v && s != 0 && off == 16'hBFF8) return put_bytes(t, 0, d, s);
    if (v && s != 0 && off == 16'hBFFC) return put_bytes(t, 1, d, s);
    if ((edges % (DIV + 1)) == DIV) return t + 64'd1;
    return t;
  endfunction

  function automatic logic [63:0] next_cmp(input logic [63:0] c, input logic v,
                                           input logic [31:0] a, input logic [31:0] d,
                                           input logic [3:0] s);
    logic [15:0] off;
    off = {a[15:2], 2'b00};
    if (v && s != 0 && off == 16'h4000) return put_bytes(c, 0, d, s);
    if (v && s != 0 && off == 16'h4004) return put_bytes(c, 1, d, s);
    return c;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_time <= 0; m_cmp <= '1; m_msip <= 0; m_edges <= 0;
      e_ready <= 0; e_rdata <= 0; e_mtip <= 0;
    end else begin
      e_mtip  <= (m_time >= m_cmp);
      e_ready <= bus.mem_valid;
      e_rdata <= (bus.mem_valid && bus.mem_wstrb == 0) ? m_read(bus.mem_addr) : 32'h0;
      m_time  <= next_time(m_time, m_edges, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      m_cmp   <= next_cmp(m_cmp, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      if (bus.mem_valid && bus.mem_wstrb[0] && bus.mem_addr[15:0] == 16'h0000)
        m_msip <= bus.mem_wdata[0];
      m_edges <= m_edges + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (reset) begin
      checks += 5;
      if (bus.mem_ready !== e_ready) begin failures++; $display("FAIL cyc_ready act=%0b exp=%0b t=%0t", bus.mem_ready, e_ready, $time); end
      if (bus.mem_rdata !== e_rdata) begin failures++; $display("FAIL cyc_rdata act=%h exp=%h t=%0t", bus.mem_rdata, e_rdata, $time); end
      if (clint_mtip !== e_mtip)     begin failures++; $display("FAIL cyc_mtip act=%0b exp=%0b t=%0t", clint_mtip, e_mtip, $time); end
      if (clint_msip !== m_msip)     begin failures++; $display("FAIL cyc_msip act=%0b exp=%0b t=%0t", clint_msip, m_msip, $time); end
      if (clint_mtime !== m_time)    begin failures++; $display("FAIL cyc_mtime act=%h exp=%h t=%0t", clint_mtime, m_time, $time); end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_wstrb = 0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(posedge clock); #1;
    bus.mem_valid = 1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
    @(posedge clock); #1;
    idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge clock); #1;
    bus.mem_valid = 1; bus.mem_addr = a; bus.mem_wstrb = 0;
    @(posedge clock); #1;
    idle();
    d = bus.mem_rdata;
  endtask

  task automatic apply_reset();
    @(negedge clock); #2;
    reset = 0; idle();
    @(negedge clock);
    chk("rst_ready", {63'h0, bus.mem_ready}, 0);
    chk("rst_rdata", {32'h0, bus.mem_rdata}, 0);
    chk("rst_mtime", clint_mtime, 0);
    chk("rst_mtip",  {63'h0, clint_mtip}, 0);
    chk("rst_msip",  {63'h0, clint_msip}, 0);
    @(posedge clock); #1;
    reset = 1;
  endtask

  task automatic wait_mtime_lo(input logic [31:0] v, input string name);
    int n;
    n = 0;
    while (clint_mtime[31:0] !== v && n < 100) begin @(negedge clock); n++; end
    chk(name, {32'h0, clint_mtime[31:0]}, {32'h0, v});
  endtask

  logic [31:0] rd;
  logic [63:0] prev;
  int n;

  initial begin
    idle();
    // Reset and divider
    apply_reset();
    repeat (9) @(posedge clock);
    @(negedge clock);
    chk("mtime_e9", clint_mtime, 0);
    chk("model_e9", m_time, 0);
    @(posedge clock); @(negedge clock);
    chk("mtime_e10", clint_mtime, 1);
    chk("model_e10", m_time, 1);
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk("mtime_e50", clint_mtime, 5);
    chk("model_e50", m_time, 5);

    // Timer interrupt
    apply_reset();
    bus_write(32'h0200_4000, 32'h5, 4'hF);
    bus_write(32'h0200_4004, 32'h0, 4'hF);
    @(negedge clock);
    wait_mtime_lo(32'h5, "reach_mtime5");
    chk("mtip_at_5", {63'h0, clint_mtip}, 0);
    @(negedge clock);
    chk("mtip_after_5", {63'h0, clint_mtip}, 1);
    bus_write(32'h0200_4000, 32'h100, 4'hF);
    chk("mtip_write_edge", {63'h0, clint_mtip}, 1);
    @(posedge clock); #1;
    chk("mtip_fall", {63'h0, clint_mtip}, 0);

    // Software interrupt
    bus_write(32'h0200_0000, 32'hFFFF_FFFF, 4'hF);
    chk("msip_set", {63'h0, clint_msip}, 1);
    bus_read(32'h0200_0000, rd);
    chk("msip_read", {32'h0, rd}, 64'h1);
    bus_write(32'h0200_0000, 32'h0, 4'hF);
    chk("msip_clr", {63'h0, clint_msip}, 0);

    // Carry and byte strobes
    bus_write(32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF);
    @(negedge clock);
    wait_mtime_lo(32'h0, "carry_wrap");
    chk("carry_mtime", clint_mtime, 64'h1_0000_0000);
    bus_read(32'h0200_BFF8, rd);
    chk("carry_lo", {32'h0, rd}, 0);
    bus_read(32'h0200_BFFC, rd);
    chk("carry_hi", {32'h0, rd}, 1);
    bus_write(32'h0200_BFFC, 32'hAABB_CCDD, 4'b0100);
    bus_read(32'h0200_BFFC, rd);
    chk("strobe_hi", {32'h0, rd}, 64'h00BB_0001);

    // Collision: the write lands on the tick edge
    prev = clint_mtime; n = 0;
    do begin @(negedge clock); n++; end while (clint_mtime === prev && n < 30);
    chk("tick_seen", {63'h0, (n < 30)}, 1);
    repeat (8) @(posedge clock);
    bus_write(32'h0200_BFF8, 32'h10, 4'hF);
    @(negedge clock);
    chk("coll_mtime", clint_mtime, 64'h00BB_0001_0000_0010);
    repeat (9) @(posedge clock);
    @(negedge clock);
    chk("coll_hold", {32'h0, clint_mtime[31:0]}, 64'h10);
    @(posedge clock); @(negedge clock);
    chk("coll_next", {32'h0, clint_mtime[31:0]}, 64'h11);
    bus_read(32'h0200_BFF8, rd);
    chk("coll_read", {32'h0, rd}, 64'h11);

    // Back-to-back reads
    apply_reset();
    @(posedge clock); #1;
    bus.mem_valid = 1; bus.mem_addr = 32'h0200_4000;
    @(posedge clock); #1;
    bus.mem_addr = 32'h0200_1234;
    chk("b2b_rdy0", {63'h0, bus.mem_ready}, 1);
    chk("b2b_dat0", {32'h0, bus.mem_rdata}, 64'hFFFF_FFFF);
    @(posedge clock); #1;
    bus.mem_addr = 32'h0200_BFF8;
    chk("b2b_rdy1", {63'h0, bus.mem_ready}, 1);
    chk("b2b_dat1", {32'h0, bus.mem_rdata}, 0);
    @(posedge clock); #1;
    idle();
    chk("b2b_rdy2", {63'h0, bus.mem_ready}, 1);
    chk("b2b_dat2", {32'h0, bus.mem_rdata}, 0);

    // Reset while a request is pending
    @(posedge clock); #1;
    bus.mem_valid = 1; bus.mem_addr = 32'h0200_4000;
    @(negedge clock); #2;
    reset = 0;
    @(posedge clock); #1;
    idle();
    chk("rst_pend_ready", {63'h0, bus.mem_ready}, 0);
    @(posedge clock); #1;
    chk("rst_pend_ready2", {63'h0, bus.mem_ready}, 0);
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/clint.md
# clint

Single-hart core-local interruptor for the small RISC-V core. It is a memory-mapped responder on the core's native data bus, decoded in the `clint_base_addr`..`clint_top_addr` window (0x2000000–0x200C000). It holds the 64-bit `mtime` counter, advanced by an RTC tick derived from the core clock, plus `mtimecmp` and `msip`. It drives the machine timer and software interrupt lines plus the `time` CSR value.

## Interface
- `clk_divider_rtc`, default 9: tick every `clk_divider_rtc`+1 clocks (clk_freq/rtc_freq−1).
- `reset`  in  1  asynchronous, active-low reset
- `clock`  in  1  core clock
- `mem_valid`  in  1  request strobe, one cycle per request; already qualified by the interconnect for the CLINT window
- `mem_addr`  in  32  byte address; only `mem_addr[15:2]` is decoded
- `mem_wdata`  in  32  write data
- `mem_wstrb`  in  4  byte write enables; 0000 = read
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1
- `mem_ready`  out  1  response strobe
- `clint_msip`  out  1  machine software interrupt pending
- `clint_mtip`  out  1  machine timer interrupt pending
- `clint_mtime`  out  64  current `mtime`, for the `time`/`timeh` CSRs

## Operation
- Register map (offset = `mem_addr[15:0]`):
  - 0x0000 `msip`: bit 0 R/W, bits 31:1 read 0.
  - 0x4000 `mtimecmp[31:0]`, 0x4004 `mtimecmp[63:32]`: R/W.
  - 0xBFF8 `mtime[31:0]`, 0xBFFC `mtime[63:32]`: R/W.
  - All other offsets read 0; writes to them are ignored.
- Writes honor `mem_wstrb` per byte. For `msip`, only byte 0 is meaningful.
- RTC divider:
  - `rtc_count` is a counter wide enough for `clk_divider_rtc`. It counts 0..`clk_divider_rtc` and then wraps to 0.
  - `tick` = (`rtc_count` == `clk_divider_rtc`).
  - With `clk_divider_rtc`=0, tick is asserted every cycle.
- `mtime` update each cycle, in priority order:
  1. A bus write to an `mtime` word replaces the strobed bytes of that word. The other word is held. No tick increment occurs that cycle.
  2. Otherwise, if `tick`, `mtime` <= `mtime`+1. This is a full 64-bit add; 0xFFFFFFFF_FFFFFFFF wraps to 0.
- `clint_mtip` <= (`mtime` >= `mtimecmp`), unsigned 64-bit compare of current register values, registered every cycle.
- `clint_msip` is a direct copy of the `msip` bit 0 register.
- `clint_mtime` is a direct copy of the `mtime` register.
- A read returns register contents as of the request cycle, before that cycle's update.

## Timing
- Reset values (asynchronous, while `reset`=0):
  - `rtc_count`=0, `mtime`=0, `mtimecmp`=0xFFFFFFFF_FFFFFFFF, `msip`=0.
  - `mem_ready`=0, `mem_rdata`=0, `clint_mtip`=0, `clint_msip`=0, `clint_mtime`=0.
- Latency is fixed at 1:
  - A request sampled with `mem_valid`=1 at edge N gives `mem_ready`=1 and `mem_rdata` for the cycle after edge N.
  - Register writes take effect at edge N.
- Back-to-back requests on consecutive cycles are supported. `mem_ready` stays high for each of them. There is no backpressure and no wait states.
- When `mem_ready`=0, `mem_rdata`=0. Write responses also return `mem_rdata`=0.
- The first tick after reset release occurs on edge `clk_divider_rtc`+1. `mtime` then reads 1 from the following cycle.
- `clint_mtip` lags `mtime`/`mtimecmp` by one cycle. Writing `mtimecmp` to a value ≤ `mtime` raises `mtip` one cycle after the write edge. Raising `mtimecmp` above `mtime` clears `mtip` with the same lag.
- Tick and `mtime` write in the same cycle: the write wins and the tick is lost. The divider keeps running.
- Reset asserted mid-transaction: outputs go to reset values immediately. No `mem_ready` is produced for the pending request.

## Test plan
- **Reset and divider:** release reset with `clk_divider_rtc`=9 and idle the bus. Required: `clint_mtime`=0 through edge 9, 1 after edge 10, 5 after edge 50. `clint_mtip`=0 throughout.
- **Timer interrupt:**
  - Write 0x4000=5 and 0x4004=0. Required: `clint_mtip` rises exactly one cycle after `mtime` becomes 5.
  - Then write 0x4000=0x100. Required: `clint_mtip` falls one cycle after the write.
- **Software interrupt:** write 0x0000=0xFFFFFFFF. Required: `clint_msip`=1 and a read of 0x0000 returns 0x00000001. Writing 0 clears it.
- **Carry and byte strobes:**
  - Write 0xBFF8=0xFFFFFFFF with `wstrb`=1111. Required: the next tick gives 0xBFF8=0 and 0xBFFC=1.
  - Write 0xBFFC=0xAABBCCDD with `wstrb`=0100. Required: only byte 2 becomes 0xBB.
- **Collision:** write 0xBFF8=0x10 on the exact tick cycle. Required: `mtime`=0x10, not 0x11, and it reads 0x11 after the next tick.
- **Bus protocol:**
  - Issue back-to-back reads of 0x4000, 0x1234, 0xBFF8 on consecutive cycles. Required: three consecutive `mem_ready` pulses with data 0xFFFFFFFF, 0, then current `mtime[31:0]`.
  - Assert `reset` while a request is pending. Required: no `mem_ready` is produced for that request.
